// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response port: one request strobe per cycle,
// in-order responses arriving at least one cycle after their request.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register. Keeps at most one
// memory request in flight and discards responses made stale by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_if,
  input  logic               stall_id,
  input  logic               flush_id,
  input  logic [1:0]         pc_sel_ex,
  input  logic [31:0]        pc_jalr_ex,
  input  logic [31:0]        alu_ans_ex,
  fetch_unit_if.master       imem,
  output logic [31:0]        pc_id,
  output logic [31:0]        pc_add4_id,
  output logic [31:0]        inst_id,
  output logic               valid_id
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_f_reg, pc_f_next;
  logic [31:0] buf_reg, buf_next;
  logic [31:0] pc_id_reg, pc_id_next;
  logic [31:0] pc_add4_id_reg, pc_add4_id_next;
  logic [31:0] inst_id_reg, inst_id_next;
  logic        valid_id_reg, valid_id_next;

  logic        redirect;
  logic        stall;
  logic [31:0] target;
  logic [31:0] pc_f_add4;
  logic        deliver;
  logic [31:0] deliver_data;

  assign redirect  = (pc_sel_ex == 2'd1) || (pc_sel_ex == 2'd2);
  assign target    = (pc_sel_ex == 2'd1) ? (pc_jalr_ex & ~32'h1) : alu_ans_ex;
  assign stall     = stall_if | stall_id;
  assign pc_f_add4 = pc_f_reg + 32'd4;

  always_comb begin
    state_next   = state_reg;
    pc_f_next    = pc_f_reg;
    buf_next     = buf_reg;
    imem.req     = 1'b0;
    imem.addr    = pc_f_reg;
    deliver      = 1'b0;
    deliver_data = imem.rdata;

    unique case (state_reg)
      S_REQ: begin
        imem.req = !redirect;
        if (redirect) begin
          pc_f_next = target;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_f_next  = target;
          state_next = imem.rvalid ? S_REQ : S_DROP;
        end else if (imem.rvalid && stall) begin
          buf_next   = imem.rdata;
          state_next = S_HOLD;
        end else if (imem.rvalid) begin
          // Deliver and issue the following request in the same cycle for full throughput.
          deliver   = 1'b1;
          imem.req  = 1'b1;
          imem.addr = pc_f_add4;
          pc_f_next = pc_f_add4;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_f_next  = target;
          state_next = S_REQ;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_data = buf_reg;
          pc_f_next    = pc_f_add4;
          state_next   = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_f_next = target;
        end
        if (imem.rvalid) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  always_comb begin
    pc_id_next      = pc_id_reg;
    pc_add4_id_next = pc_add4_id_reg;
    inst_id_next    = inst_id_reg;
    valid_id_next   = valid_id_reg;
    if (flush_id) begin
      inst_id_next  = NOP_INST;
      valid_id_next = 1'b0;
    end else if (stall_id) begin
      // hold all four IF/ID fields
    end else if (deliver) begin
      pc_id_next      = pc_f_reg;
      pc_add4_id_next = pc_f_add4;
      inst_id_next    = deliver_data;
      valid_id_next   = 1'b1;
    end else begin
      inst_id_next  = NOP_INST;
      valid_id_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_REQ;
      pc_f_reg       <= RESET_PC;
      buf_reg        <= '0;
      pc_id_reg      <= RESET_PC;
      pc_add4_id_reg <= RESET_PC + 32'd4;
      inst_id_reg    <= NOP_INST;
      valid_id_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_f_reg       <= pc_f_next;
      buf_reg        <= buf_next;
      pc_id_reg      <= pc_id_next;
      pc_add4_id_reg <= pc_add4_id_next;
      inst_id_reg    <= inst_id_next;
      valid_id_reg   <= valid_id_next;
    end
  end

  assign pc_id      = pc_id_reg;
  assign pc_add4_id = pc_add4_id_reg;
  assign inst_id    = inst_id_reg;
  assign valid_id   = valid_id_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a one-deep memory model answers requests, and
// scoreboards hold the expected request addresses and delivered PCs.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, flush_id;
  logic [1:0]  pc_sel_ex;
  logic [31:0] pc_jalr_ex, alu_ans_ex;
  logic [31:0] pc_id, pc_add4_id, inst_id;
  logic        valid_id;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .flush_id   (flush_id),
    .pc_sel_ex  (pc_sel_ex),
    .pc_jalr_ex (pc_jalr_ex),
    .alu_ans_ex (alu_ans_ex),
    .imem       (imem),
    .pc_id      (pc_id),
    .pc_add4_id (pc_add4_id),
    .inst_id    (inst_id),
    .valid_id   (valid_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_pc_q[$];

  bit          pend;
  logic [31:0] pend_addr;
  bit          mem_hold;
  bit          last_req;
  logic [31:0] last_addr;
  bit          last_stall_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // One clock cycle: memory drives its response, request is observed,
  // clock edge, then any new ID-stage delivery is scoreboarded.
  task automatic step();
    bit          rv;
    logic [31:0] pc_exp;
    rv = pend && !mem_hold;
    imem.rvalid = rv;
    imem.rdata  = rv ? mem_word(pend_addr) : 32'h0;
    #1;
    last_req      = imem.req;
    last_addr     = imem.addr;
    last_stall_id = stall_id;
    if (!rst && last_req) begin
      check("one_outstanding", 32'(pend && !rv), 32'd0);
      if (exp_req_q.size() == 0)
        check("req_expected", 32'(exp_req_q.size()), 32'd1);
      else
        check("req_addr", last_addr, exp_req_q.pop_front());
      $display("req  addr=%h", last_addr);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (rv) pend = 1'b0;
      if (last_req) begin
        pend      = 1'b1;
        pend_addr = last_addr;
      end
      if (valid_id && !last_stall_id) begin
        if (exp_pc_q.size() == 0) begin
          check("id_expected", 32'(exp_pc_q.size()), 32'd1);
        end else begin
          pc_exp = exp_pc_q.pop_front();
          check("id_pc", pc_id, pc_exp);
          check("id_pc4", pc_add4_id, pc_exp + 32'd4);
          check("id_inst", inst_id, mem_word(pc_exp));
        end
        $display("id   pc=%h inst=%h", pc_id, inst_id);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush_id = 1'b0;
    pc_sel_ex = 2'd0; pc_jalr_ex = '0; alu_ans_ex = '0;
    imem.rvalid = 1'b0; imem.rdata = '0;
    pend = 1'b0; pend_addr = '0; mem_hold = 1'b0;
    step(); step();
    check("rst_valid", 32'(valid_id), 32'd0);
    check("rst_inst", inst_id, 32'h0000_0013);
    check("rst_pc", pc_id, 32'h0);
    check("rst_pc4", pc_add4_id, 32'h4);
    rst = 1'b0;

    // 1: streaming fetch, one instruction per cycle
    foreach (exp_req_q[i]) ;
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
    exp_req_q.push_back(32'hC); exp_req_q.push_back(32'h10);
    exp_pc_q.push_back(32'h0); exp_pc_q.push_back(32'h4);
    exp_pc_q.push_back(32'h8); exp_pc_q.push_back(32'hC);
    step(); check("t1_req_c0", 32'(last_req), 32'd1);
    check("t1_first_not_yet", 32'(valid_id), 32'd0);
    step(); check("t1_req_c1", 32'(last_req), 32'd1);
    check("t1_first_valid", 32'(valid_id), 32'd1);
    step(); check("t1_req_c2", 32'(last_req), 32'd1);

    // 2: stall while the response for 0x8 arrives
    stall_if = 1'b1; stall_id = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_no_req", 32'(last_req), 32'd0);
      check("t2_hold_pc", pc_id, 32'h4);
      check("t2_hold_inst", inst_id, mem_word(32'h4));
    end
    stall_if = 1'b0; stall_id = 1'b0;
    step(); check("t2_release_no_req", 32'(last_req), 32'd0);
    step(); step();

    // 3: branch redirect with the request still outstanding
    exp_req_q.push_back(32'h100); exp_req_q.push_back(32'h104);
    exp_pc_q.push_back(32'h100);
    mem_hold = 1'b1; pc_sel_ex = 2'd2; alu_ans_ex = 32'h100;
    step(); check("t3_redirect_no_req", 32'(last_req), 32'd0);
    mem_hold = 1'b0; pc_sel_ex = 2'd0;
    step(); check("t3_drop_no_req", 32'(last_req), 32'd0);
    check("t3_discard", 32'(valid_id), 32'd0);
    step(); check("t3_refetch", 32'(last_req), 32'd1);
    step();

    // 4: redirect in WAIT with response, then jalr while in REQ
    pc_sel_ex = 2'd2; alu_ans_ex = 32'h180;
    step(); check("t4_wait_redirect_no_req", 32'(last_req), 32'd0);
    check("t4_discard", 32'(valid_id), 32'd0);
    pc_sel_ex = 2'd1; pc_jalr_ex = 32'h203;
    exp_req_q.push_back(32'h202); exp_req_q.push_back(32'h206);
    exp_pc_q.push_back(32'h202); exp_pc_q.push_back(32'h206);
    step(); check("t4_jalr_no_req", 32'(last_req), 32'd0);
    pc_sel_ex = 2'd0;
    step(); step();

    // 5: flush beats stall_id
    flush_id = 1'b1; stall_id = 1'b1;
    step();
    check("t5_flush_valid", 32'(valid_id), 32'd0);
    check("t5_flush_inst", inst_id, 32'h0000_0013);
    check("t5_flush_pc", pc_id, 32'h202);
    flush_id = 1'b0; stall_id = 1'b0;
    step();

    // 6: reset while a word is buffered
    exp_req_q.push_back(32'h20A);
    step();
    stall_id = 1'b1;
    step();
    rst = 1'b1; stall_id = 1'b0;
    step();
    rst = 1'b0;
    check("t6_req", 32'(imem.req), 32'd1);
    check("t6_addr", imem.addr, 32'h0);
    check("t6_valid", 32'(valid_id), 32'd0);
    check("t6_inst", inst_id, 32'h0000_0013);
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
    exp_pc_q.push_back(32'h0); exp_pc_q.push_back(32'h4);
    step(); step(); step();
    rst = 1'b1;
    step();

    check("req_q_drained", 32'(exp_req_q.size()), 32'd0);
    check("pc_q_drained", 32'(exp_pc_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
